// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: byte-lane word SRAM with programmable wait states and core stall.
// Optional memory-mapped timer (COUNT/COMPARE + interrupt) enabled by defining MMIO_TIMER_EN.
module dbus_sram_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TIMER_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ram_stall_o,
  output logic        ram_err_o,
  output logic        timer_int_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:2] r_addr;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  logic [31:0] w_baddr;
  logic        w_sram_hit;
  logic        w_tmr_sel;
  logic        w_hit_any;
  logic [31:0] w_tmr_rdata;
  logic [31:0] w_rd_word;
  logic        w_access;
  logic        w_sram_wr;
  logic        w_unused;

  assign w_baddr    = {r_addr, 2'b00};
  assign w_sram_hit = ((w_baddr ^ BASE_ADDR) >> (ADDR_W + 2)) == 32'd0;
  assign w_hit_any  = w_sram_hit | w_tmr_sel;
  assign w_access   = (r_state == S_ACCESS);
  // Timer addresses take precedence over the SRAM range.
  assign w_sram_wr  = w_access & r_we & w_sram_hit & ~w_tmr_sel;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (ram_ce_i) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    if (w_tmr_sel)       w_rd_word = w_tmr_rdata;
    else if (w_sram_hit) w_rd_word = r_mem[r_addr[ADDR_W+1:2]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_access & ~w_hit_any;
      if (r_state == S_IDLE && ram_ce_i) begin
        r_addr  <= ram_addr_i[31:2];
        r_we    <= ram_we_i;
        r_sel   <= ram_sel_i;
        r_wdata <= ram_data_i;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) r_rdata <= r_we ? 32'd0 : w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[r_addr[ADDR_W+1:2]][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tint;
  logic        w_cnt_sel;
  logic        w_cmp_sel;
  logic        w_cmp_wr;

  assign w_cnt_sel   = (w_baddr == TIMER_ADDR);
  assign w_cmp_sel   = (w_baddr == (TIMER_ADDR + 32'd4));
  assign w_tmr_sel   = w_cnt_sel | w_cmp_sel;
  assign w_tmr_rdata = w_cnt_sel ? r_count : r_compare;
  assign w_cmp_wr    = w_access & r_we & w_cmp_sel;
  assign timer_int_o = r_tint;
  assign w_unused    = ^ram_addr_i[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count   <= '0;
      r_compare <= '0;
      r_tint    <= 1'b0;
    end else begin
      r_count <= r_count + 32'd1;
      if (w_cmp_wr) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (r_sel[b]) r_compare[8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
      // A COMPARE write on the same edge as a match wins and clears the interrupt.
      if (w_cmp_wr)                                     r_tint <= 1'b0;
      else if (r_count == r_compare && r_compare != 0)  r_tint <= 1'b1;
    end
  end
`else
  assign w_tmr_sel   = 1'b0;
  assign w_tmr_rdata = '0;
  assign timer_int_o = 1'b0;
  assign w_unused    = ^{ram_addr_i[1:0], TIMER_ADDR};
`endif

  assign ram_stall_o = rstn & (((r_state == S_IDLE) & ram_ce_i) |
                               (r_state == S_WAIT) | (r_state == S_ACCESS));
  assign ram_data_o  = r_rdata;
  assign ram_err_o   = r_err;

endmodule
